tick_gen: RTL
=============

# tick_gen

Programmable tick generator that drives the enable input of the LED flasher stage. It synchronises the board run switch and a 2-bit speed selector, then counts system clocks against one of four compile-time periods. It emits a single-cycle `o_tick` pulse each time a period elapses, so the downstream flasher toggles exactly once per period.

## Interface

Parameters:
- `NB_COUNT`, 32, counter width in bits.
- `LIMIT_0`, 50_000_000, period in clocks for `i_sel`=0.
- `LIMIT_1`, 25_000_000, period in clocks for `i_sel`=1.
- `LIMIT_2`, 12_500_000, period in clocks for `i_sel`=2.
- `LIMIT_3`, 6_250_000, period in clocks for `i_sel`=3.
- Each `LIMIT_n` must satisfy 2 ≤ `LIMIT_n` ≤ 2^`NB_COUNT`.

Ports:
- `clock`, in, 1, system clock. All logic is on the rising edge.
- `i_reset`, in, 1, asynchronous active-low reset.
- `i_run`, in, 1, asynchronous level from a switch. 1 = count, 0 = pause.
- `i_sel`, in, 2, asynchronous speed select from switches.
- `o_tick`, out, 1, registered single-cycle pulse. Connects to the flasher enable.
- `o_count`, out, `NB_COUNT`, current counter value.
- `o_sel`, out, 2, synchronised selector currently in effect.

## Operation

- Synchronisers:
  - `i_run` and `i_sel` each pass through two flops, giving `run_s` and `sel_s`.
  - A third register `sel_q` holds the previous `sel_s`.
  - All of these reset to 0.
- Period selection: `limit` = `LIMIT_n` for n = `sel_s`, chosen by combinational mux.
- Counter update, in priority order, each clock:
  1. `sel_s` ≠ `sel_q`: `count` ← 0, `o_tick` ← 0. This applies regardless of `run_s`. A speed change always restarts a full period.
  2. `run_s` = 0: `count` holds, `o_tick` ← 0. This is pause.
  3. `count` ≥ `limit`−1: `count` ← 0, `o_tick` ← 1. The ≥ compare is defensive; rule 1 keeps `count` < `limit`.
  4. Otherwise: `count` ← `count`+1, `o_tick` ← 0.
- Arithmetic: unsigned, `NB_COUNT` bits. The compare uses `limit`−1, computed at `NB_COUNT` width. The counter never wraps through 2^`NB_COUNT`.
- `o_sel` = `sel_s`. `o_count` = `count`.
- Reset values: `count`=0, `o_tick`=0, `o_sel`=0, all synchroniser flops 0.
- Reset mid-period: asserting `i_reset` clears everything immediately, without waiting for a clock. After release, counting restarts from 0 once `run_s` returns high through the synchroniser.

## Timing

- Input latency: a change on `i_run`/`i_sel` reaches `run_s`/`sel_s` on the 2nd rising edge after setup.
- First tick:
  - Let edge E0 be the first edge that samples `i_run`=1, with `i_sel` stable and `count`=0.
  - `o_tick` is high for exactly one cycle after edge E0+`limit`+1.
- Steady state: `o_tick` pulses every `limit` clocks, exactly one cycle wide. `o_tick` is never high on two consecutive cycles, since `limit` ≥ 2.
- Pause:
  - `run_s` falling stops counting on that same edge.
  - When `run_s` rises again, counting resumes from the held `count`.
  - The remaining period = `limit`−1−`count` edges before the terminal edge.
- Speed change:
  - On the edge where `sel_s` first differs from `sel_q`, `count` ← 0 and any pending tick is suppressed.
  - The next tick comes `limit`(new) edges after that edge, not counting paused cycles.
- Simultaneous events: if a `sel` change coincides with the terminal count, the `sel` change wins. `count` ← 0 and no tick is issued.

## Test plan

Overrides: `LIMIT_0`=4, `LIMIT_1`=6, `LIMIT_2`=2, `LIMIT_3`=9, `NB_COUNT`=8.

- Reset: hold `i_reset`=0 with `i_run`=1 toggling the clock. Required: `o_tick`=0, `o_count`=0, `o_sel`=0. Assert `i_reset` low asynchronously mid-cycle; outputs clear before the next edge.
- Basic period: `i_sel`=0, raise `i_run`. Required: first `o_tick` after edge E0+5, then pulses at 4-cycle spacing, each exactly 1 cycle wide. Count 8 ticks in 32 cycles.
- Minimum period: `i_sel`=2. Required: `o_tick` alternates 1,0,1,0 in steady state. `o_count` alternates 0,1.
- Pause/resume: `i_sel`=1. Drop `i_run` when `o_count`=3 and hold it low 10 cycles. Required: `o_count` frozen at 3 (±1 for sync latency, checked against `run_s`), no ticks. After resume, the tick arrives when `o_count` reaches 5.
- Speed change at terminal: `i_sel`=0. Change to 3 so that `sel_s` changes on the edge where `o_count`=3. Required: no tick on that edge, `o_count`=0, `o_sel`=3, next tick 9 edges later.
- Flasher integration: connect `o_tick` to the flasher enable. With `i_sel`=0, the flasher output toggles 0000↔1111 once every 4 clocks.

Source files
------------

// File: rtl/tick_gen.sv
// tick_gen: programmable single-cycle tick for the LED flasher enable.
// Ports: clock, i_reset (async, low), i_run, i_sel[1:0] -> o_tick, o_count, o_sel.
module tick_gen #(
  parameter int NB_COUNT = 32,
  parameter longint unsigned LIMIT_0 = 64'd50_000_000,
  parameter longint unsigned LIMIT_1 = 64'd25_000_000,
  parameter longint unsigned LIMIT_2 = 64'd12_500_000,
  parameter longint unsigned LIMIT_3 = 64'd6_250_000
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic [1:0]          i_sel,
  output logic                o_tick,
  output logic [NB_COUNT-1:0] o_count,
  output logic [1:0]          o_sel
);

  // terminal values (limit-1) at counter width; LIMIT = 2^NB_COUNT fits
  localparam logic [NB_COUNT-1:0] TERM_0 =
    NB_COUNT'(LIMIT_0 - 64'd1);
  localparam logic [NB_COUNT-1:0] TERM_1 =
    NB_COUNT'(LIMIT_1 - 64'd1);
  localparam logic [NB_COUNT-1:0] TERM_2 =
    NB_COUNT'(LIMIT_2 - 64'd1);
  localparam logic [NB_COUNT-1:0] TERM_3 =
    NB_COUNT'(LIMIT_3 - 64'd1);

  logic                run_m;
  logic                run_s;
  logic [1:0]          sel_m;
  logic [1:0]          sel_s;
  logic [1:0]          sel_q;
  logic [NB_COUNT-1:0] count;
  logic [NB_COUNT-1:0] term;
  logic                tick;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      run_m <= 1'b0;
      run_s <= 1'b0;
      sel_m <= 2'd0;
      sel_s <= 2'd0;
      sel_q <= 2'd0;
    end else begin
      run_m <= i_run;
      run_s <= run_m;
      sel_m <= i_sel;
      sel_s <= sel_m;
      sel_q <= sel_s;
    end
  end

  always_comb begin
    term = TERM_0;
    unique case (sel_s)
      2'd0: term = TERM_0;
      2'd1: term = TERM_1;
      2'd2: term = TERM_2;
      2'd3: term = TERM_3;
    endcase
  end

  // a speed change outranks both pause and the terminal count,
  // so a new selection always starts a full fresh period
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (sel_s != sel_q) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (!run_s) begin
      tick  <= 1'b0;
    end else if (count >= term) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + NB_COUNT'(1);
      tick  <= 1'b0;
    end
  end

  assign o_tick  = tick;
  assign o_count = count;
  assign o_sel   = sel_s;

endmodule
